// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweeper: gate opcodes and sweep states.
package tt_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_BUF  = 3'd0;
   localparam logic [OP_W-1:0] OP_NOT  = 3'd1;
   localparam logic [OP_W-1:0] OP_AND  = 3'd2;
   localparam logic [OP_W-1:0] OP_NAND = 3'd3;
   localparam logic [OP_W-1:0] OP_OR   = 3'd4;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd6;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Row stream carrying one truth-table row and its channel results per handshake.
interface truth_table_sweeper_if #(
   parameter int N_IN = 2,
   parameter int N_CH = 3
) ();

   logic            out_valid;
   logic            out_ready;
   logic [N_IN-1:0] out_vec;
   logic [N_CH-1:0] out_z;

   modport master (
      output out_valid,
      output out_vec,
      output out_z,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_vec,
      input  out_z,
      output out_ready
   );

endinterface

// File: rtl/tt_gate_eval.sv
// One gate channel: applies a 3-bit opcode to an input row, purely combinational.
module tt_gate_eval
   import tt_pkg::*;
#(
   parameter int N_IN = 2
) (
   input  logic [OP_W-1:0] op,
   input  logic [N_IN-1:0] vec,
   output logic            z
);

   // BUF/NOT look only at x0; every other op reduces across the whole row.
   always_comb begin
      z = 1'b0;
      case (op)
         OP_BUF:  z = vec[0];
         OP_NOT:  z = ~vec[0];
         OP_AND:  z = &vec;
         OP_NAND: z = ~&vec;
         OP_OR:   z = |vec;
         OP_NOR:  z = ~|vec;
         OP_XOR:  z = ^vec;
         OP_XNOR: z = ~^vec;
      endcase
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2^N_IN input rows through N_CH gate channels and streams each row out.
// Optional TT_SIG_EN adds per-channel ones counters (ones_cnt) as a sweep signature.
module truth_table_sweeper
   import tt_pkg::*;
#(
   parameter int N_IN = 2,
   parameter int N_CH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [OP_W*N_CH-1:0]  mode,
   truth_table_sweeper_if.master stream,
   output logic                  busy,
   output logic                  done
`ifdef TT_SIG_EN
   ,
   output logic [N_CH*(N_IN+1)-1:0] ones_cnt
`endif
);

   state_t                state_q, state_d;
   logic [N_IN-1:0]       vec_q, vec_d;
   logic [OP_W*N_CH-1:0]  mode_q, mode_d;
   logic [N_CH-1:0]       z;
   logic                  fire;
   logic                  start_ok;

   assign fire     = (state_q == RUN) && stream.out_ready;
   assign start_ok = (state_q == IDLE) && start;

   genvar c;
   generate
      for (c = 0; c < N_CH; c++) begin : g_ch
         tt_gate_eval #(.N_IN(N_IN)) u_eval (
            .op  (mode_q[OP_W*c +: OP_W]),
            .vec (vec_q),
            .z   (z[c])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         mode_q  <= mode_d;
      end
   end

   // The all-ones row is terminal, so the counter never needs to wrap.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d  = mode;
               vec_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (fire) begin
               if (vec_q == {N_IN{1'b1}}) begin
                  state_d = DONE;
               end else begin
                  vec_d = vec_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign stream.out_valid = (state_q == RUN);
   assign stream.out_vec   = vec_q;
   assign stream.out_z     = z;
   assign busy             = (state_q == RUN);
   assign done             = (state_q == DONE);

`ifdef TT_SIG_EN
   logic [N_CH*(N_IN+1)-1:0] ones_q;

   // Each field has one extra bit so a channel that is high on every row still fits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_q <= '0;
      end else if (start_ok) begin
         ones_q <= '0;
      end else if (fire) begin
         for (int i = 0; i < N_CH; i++) begin
            ones_q[i*(N_IN+1) +: (N_IN+1)] <=
               ones_q[i*(N_IN+1) +: (N_IN+1)] + (N_IN+1)'(z[i]);
         end
      end
   end

   assign ones_cnt = ones_q;
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed, table-driven bench for truth_table_sweeper (N_IN=2/N_CH=3 and N_IN=3/N_CH=1).
module tb_truth_table_sweeper;
   import tt_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start2, start3;
   logic [8:0] mode2;
   logic [2:0] mode3;
   logic       busy2, done2, busy3, done3;

   always #5 clk = ~clk;

   truth_table_sweeper_if #(.N_IN(2), .N_CH(3)) s2 ();
   truth_table_sweeper_if #(.N_IN(3), .N_CH(1)) s3 ();

`ifdef TT_SIG_EN
   logic [8:0] cnt2;
   logic [3:0] cnt3;
`endif

   truth_table_sweeper #(.N_IN(2), .N_CH(3)) dut2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start2),
      .mode   (mode2),
      .stream (s2.master),
      .busy   (busy2),
      .done   (done2)
`ifdef TT_SIG_EN
      ,
      .ones_cnt (cnt2)
`endif
   );

   truth_table_sweeper #(.N_IN(3), .N_CH(1)) dut3 (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start3),
      .mode   (mode3),
      .stream (s3.master),
      .busy   (busy3),
      .done   (done3)
`ifdef TT_SIG_EN
      ,
      .ones_cnt (cnt3)
`endif
   );

   typedef struct {
      logic [1:0] vec;
      logic [2:0] z;
   } row_t;

   row_t       rows[4];
   logic [8:0] mode_a;
   logic [7:0] xor_exp;
   int         tests_run    = 0;
   int         tests_failed = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Pulses start on the small instance; returns in the cycle showing row 0.
   task automatic apply_stimulus(input logic [8:0] m);
      mode2  = m;
      start2 = 1'b1;
      step();
      start2 = 1'b0;
   endtask

   task automatic check_row2(input string tag, input int i);
      check_output({tag, " valid"}, 32'(s2.out_valid), 32'd1);
      check_output({tag, " busy"},  32'(busy2),        32'd1);
      check_output({tag, " vec"},   32'(s2.out_vec),   32'(rows[i].vec));
      check_output({tag, " z"},     32'(s2.out_z),     32'(rows[i].z));
   endtask

   task automatic check_done2(input string tag);
      check_output({tag, " done"},  32'(done2),        32'd1);
      check_output({tag, " busy"},  32'(busy2),        32'd0);
      check_output({tag, " valid"}, 32'(s2.out_valid), 32'd0);
   endtask

   task automatic run_rows2(input string tag);
      for (int i = 0; i < 4; i++) begin
         check_row2($sformatf("%s row%0d", tag, i), i);
         step();
      end
      check_done2(tag);
   endtask

   initial begin
      // z bit0 = BUF, bit1 = XNOR, bit2 = NAND
      mode_a  = {OP_NAND, OP_XNOR, OP_BUF};
      rows[0] = '{vec: 2'd0, z: 3'b110};
      rows[1] = '{vec: 2'd1, z: 3'b101};
      rows[2] = '{vec: 2'd2, z: 3'b100};
      rows[3] = '{vec: 2'd3, z: 3'b011};
      xor_exp = 8'b1001_0110;

      rst_n        = 1'b0;
      start2       = 1'b0;
      start3       = 1'b0;
      mode2        = '0;
      mode3        = '0;
      s2.out_ready = 1'b1;
      s3.out_ready = 1'b1;
      step();
      step();

      check_output("reset valid", 32'(s2.out_valid), 32'd0);
      check_output("reset vec",   32'(s2.out_vec),   32'd0);
      check_output("reset z",     32'(s2.out_z),     32'd0);
      check_output("reset busy",  32'(busy2),        32'd0);
      check_output("reset done",  32'(done2),        32'd0);
`ifdef TT_SIG_EN
      check_output("reset cnt",   32'(cnt2),         32'd0);
`endif
      rst_n = 1'b1;
      step();

      // Basic sweep with ready held high.
      apply_stimulus(mode_a);
      run_rows2("basic");
`ifdef TT_SIG_EN
      check_output("basic ones_cnt", 32'(cnt2), 32'({3'd3, 3'd2, 3'd2}));
`endif
      step();
      check_output("basic done width", 32'(done2), 32'd0);

      // Three-input XOR sweep: 8 busy rows then done at k+9.
      mode3  = OP_XOR;
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check_output($sformatf("xor row%0d busy", i), 32'(busy3),      32'd1);
         check_output($sformatf("xor row%0d vec", i),  32'(s3.out_vec), 32'(i));
         check_output($sformatf("xor row%0d z", i),    32'(s3.out_z),   32'(xor_exp[i]));
         step();
      end
      check_output("xor done", 32'(done3), 32'd1);
      check_output("xor busy", 32'(busy3), 32'd0);
`ifdef TT_SIG_EN
      check_output("xor ones_cnt", 32'(cnt3), 32'd4);
`endif
      step();
      check_output("xor done width", 32'(done3), 32'd0);

      // Backpressure on row 2 for three edges.
      apply_stimulus(mode_a);
`ifdef TT_SIG_EN
      check_output("cnt cleared", 32'(cnt2), 32'd0);
`endif
      check_row2("bp row0", 0);
      step();
      check_row2("bp row1", 1);
      step();
      check_row2("bp row2", 2);
      s2.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_row2($sformatf("bp hold%0d", i), 2);
      end
      s2.out_ready = 1'b1;
      step();
      check_row2("bp row3", 3);
      step();
      check_done2("bp");
      step();

      // Start mid-sweep and in the DONE cycle, with mode changed mid-sweep.
      apply_stimulus(mode_a);
      check_row2("ign row0", 0);
      step();
      check_row2("ign row1", 1);
      mode2  = {OP_XOR, OP_XOR, OP_XOR};
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      check_row2("ign row2", 2);
      step();
      check_row2("ign row3", 3);
      step();
      check_done2("ign");
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_output($sformatf("ign idle%0d done", i),  32'(done2),        32'd0);
         check_output($sformatf("ign idle%0d busy", i),  32'(busy2),        32'd0);
         check_output($sformatf("ign idle%0d valid", i), 32'(s2.out_valid), 32'd0);
         step();
      end

      // Asynchronous reset while row 1 is presented.
      apply_stimulus(mode_a);
      check_row2("rst row0", 0);
      step();
      check_row2("rst row1", 1);
      rst_n = 1'b0;
      #1;
      check_output("rst async valid", 32'(s2.out_valid), 32'd0);
      check_output("rst async vec",   32'(s2.out_vec),   32'd0);
      check_output("rst async z",     32'(s2.out_z),     32'd0);
      check_output("rst async busy",  32'(busy2),        32'd0);
      check_output("rst async done",  32'(done2),        32'd0);
      step();
      rst_n = 1'b1;
      step();
      check_output("rst no done", 32'(done2), 32'd0);
      apply_stimulus(mode_a);
      run_rows2("after rst");
      step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
